data_bus_arbiter: RTL and testbench

//  Shares the single data-memory/peripheral bus between two masters: M0 (riscv_core

---
 rtl/data_bus_arbiter.sv | 169 ++++++++++++++++
 tb/tb_data_bus_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : data_bus_arbiter
// Description : Two-master arbiter for the shared data bus. Registers the
//               winner's request, waits for bus_ready or a timeout, and returns
//               read data plus a one-cycle done pulse to the owner.
// Revision    : 1.0 - initial release
// ============================================================================
module data_bus_arbiter #(
    parameter int unsigned PRIORITY_MODE  = 0,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] m0_address,
    input  logic [31:0] m0_write_data,
    input  logic [2:0]  m0_format,
    input  logic        m0_read_enable,
    input  logic        m0_write_enable,
    output logic [31:0] m0_data_fetched,
    output logic        m0_done,
    output logic        m0_error,
    input  logic [31:0] m1_address,
    input  logic [31:0] m1_write_data,
    input  logic [2:0]  m1_format,
    input  logic        m1_read_enable,
    input  logic        m1_write_enable,
    output logic [31:0] m1_data_fetched,
    output logic        m1_done,
    output logic        m1_error,
    output logic [31:0] bus_address,
    output logic [31:0] bus_write_data,
    output logic [2:0]  bus_format,
    output logic        bus_read_enable,
    output logic        bus_write_enable,
    input  logic [31:0] bus_data_fetched,
    input  logic        bus_ready,
    output logic        bus_owner,
    output logic        bus_busy
);

    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        last_grant;
    logic [15:0] count;
    logic [15:0] count_inc;
    logic        m0_req;
    logic        m1_req;
    logic        any_req;
    logic        grant;
    logic        timeout_hit;

    always_comb begin
        m0_req      = m0_read_enable | m0_write_enable;
        m1_req      = m1_read_enable | m1_write_enable;
        any_req     = m0_req | m1_req;
        grant       = m1_req;
        if (m0_req && m1_req) begin
            grant = (PRIORITY_MODE == 0) ? ~last_grant : 1'b0;
        end
        count_inc   = count + 16'd1;
        timeout_hit = (TIMEOUT_CYCLES != 0) && (count_inc == TIMEOUT_LIMIT);
        state_next  = state;
        case (state)
            IDLE:    if (any_req) state_next = BUSY;
            BUSY:    if (bus_ready || timeout_hit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    assign bus_busy = (state == BUSY);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            m0_data_fetched  <= 32'd0;
            m0_done          <= 1'b0;
            m0_error         <= 1'b0;
            m1_data_fetched  <= 32'd0;
            m1_done          <= 1'b0;
            m1_error         <= 1'b0;
            bus_address      <= 32'd0;
            bus_write_data   <= 32'd0;
            bus_format       <= 3'd0;
            bus_read_enable  <= 1'b0;
            bus_write_enable <= 1'b0;
            bus_owner        <= 1'b0;
            last_grant       <= 1'b1;
            count            <= 16'd0;
        end else begin
            m0_done <= 1'b0;
            m1_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        bus_owner <= grant;
                        count     <= 16'd0;
                        // A simultaneous read and write request is issued as a write.
                        if (grant) begin
                            bus_address      <= m1_address;
                            bus_write_data   <= m1_write_data;
                            bus_format       <= m1_format;
                            bus_write_enable <= m1_write_enable;
                            bus_read_enable  <= m1_read_enable & ~m1_write_enable;
                            m1_error         <= 1'b0;
                        end else begin
                            bus_address      <= m0_address;
                            bus_write_data   <= m0_write_data;
                            bus_format       <= m0_format;
                            bus_write_enable <= m0_write_enable;
                            bus_read_enable  <= m0_read_enable & ~m0_write_enable;
                            m0_error         <= 1'b0;
                        end
                    end
                end
                BUSY: begin
                    if (bus_ready) begin
                        bus_read_enable  <= 1'b0;
                        bus_write_enable <= 1'b0;
                        if (bus_owner) begin
                            m1_done <= 1'b1;
                            if (bus_read_enable) m1_data_fetched <= bus_data_fetched;
                        end else begin
                            m0_done <= 1'b1;
                            if (bus_read_enable) m0_data_fetched <= bus_data_fetched;
                        end
                    end else begin
                        count <= count_inc;
                        if (timeout_hit) begin
                            bus_read_enable  <= 1'b0;
                            bus_write_enable <= 1'b0;
                            if (bus_owner) begin
                                m1_done         <= 1'b1;
                                m1_error        <= 1'b1;
                                m1_data_fetched <= 32'd0;
                            end else begin
                                m0_done         <= 1'b1;
                                m0_error        <= 1'b1;
                                m0_data_fetched <= 32'd0;
                            end
                        end
                    end
                end
                DONE: begin
                    last_grant <= bus_owner;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_bus_arbiter.sv
`default_nettype none
// Directed self-checking bench for data_bus_arbiter: a round-robin instance and a
// fixed-priority instance share all master and slave stimulus.
module tb_data_bus_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] m0_address = '0, m0_write_data = '0, m1_address = '0, m1_write_data = '0;
    logic [2:0]  m0_format = '0, m1_format = '0;
    logic        m0_read_enable = 0, m0_write_enable = 0, m1_read_enable = 0, m1_write_enable = 0;
    logic [31:0] bus_data_fetched = '0;
    logic        bus_ready = 0;

    logic [31:0] m0_data_fetched, m1_data_fetched, bus_address, bus_write_data;
    logic        m0_done, m0_error, m1_done, m1_error;
    logic [2:0]  bus_format;
    logic        bus_read_enable, bus_write_enable, bus_owner, bus_busy;

    logic [31:0] fp_m0_data_fetched, fp_m1_data_fetched, fp_bus_address, fp_bus_write_data;
    logic        fp_m0_done, fp_m0_error, fp_m1_done, fp_m1_error;
    logic [2:0]  fp_bus_format;
    logic        fp_bus_read_enable, fp_bus_write_enable, fp_bus_owner, fp_bus_busy;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    data_bus_arbiter #(.PRIORITY_MODE(0), .TIMEOUT_CYCLES(4)) dut (
        .clock(clock), .reset(reset),
        .m0_address(m0_address), .m0_write_data(m0_write_data), .m0_format(m0_format),
        .m0_read_enable(m0_read_enable), .m0_write_enable(m0_write_enable),
        .m0_data_fetched(m0_data_fetched), .m0_done(m0_done), .m0_error(m0_error),
        .m1_address(m1_address), .m1_write_data(m1_write_data), .m1_format(m1_format),
        .m1_read_enable(m1_read_enable), .m1_write_enable(m1_write_enable),
        .m1_data_fetched(m1_data_fetched), .m1_done(m1_done), .m1_error(m1_error),
        .bus_address(bus_address), .bus_write_data(bus_write_data), .bus_format(bus_format),
        .bus_read_enable(bus_read_enable), .bus_write_enable(bus_write_enable),
        .bus_data_fetched(bus_data_fetched), .bus_ready(bus_ready),
        .bus_owner(bus_owner), .bus_busy(bus_busy)
    );

    data_bus_arbiter #(.PRIORITY_MODE(1), .TIMEOUT_CYCLES(4)) dut_fp (
        .clock(clock), .reset(reset),
        .m0_address(m0_address), .m0_write_data(m0_write_data), .m0_format(m0_format),
        .m0_read_enable(m0_read_enable), .m0_write_enable(m0_write_enable),
        .m0_data_fetched(fp_m0_data_fetched), .m0_done(fp_m0_done), .m0_error(fp_m0_error),
        .m1_address(m1_address), .m1_write_data(m1_write_data), .m1_format(m1_format),
        .m1_read_enable(m1_read_enable), .m1_write_enable(m1_write_enable),
        .m1_data_fetched(fp_m1_data_fetched), .m1_done(fp_m1_done), .m1_error(fp_m1_error),
        .bus_address(fp_bus_address), .bus_write_data(fp_bus_write_data), .bus_format(fp_bus_format),
        .bus_read_enable(fp_bus_read_enable), .bus_write_enable(fp_bus_write_enable),
        .bus_data_fetched(bus_data_fetched), .bus_ready(bus_ready),
        .bus_owner(fp_bus_owner), .bus_busy(fp_bus_busy)
    );

    task automatic apply_reset();
        reset = 1'b0;
        m0_read_enable = 0; m0_write_enable = 0; m1_read_enable = 0; m1_write_enable = 0;
        bus_ready = 0; bus_data_fetched = '0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
    endtask

    // Runs one transaction with an immediately-ready slave; ok=0 if done never came.
    task automatic run_txn(input bit master, input bit re, input bit we,
                           input logic [31:0] addr, input logic [31:0] rdata, output bit ok);
        ok = 0;
        if (master) begin m1_address = addr; m1_read_enable = re; m1_write_enable = we; end
        else        begin m0_address = addr; m0_read_enable = re; m0_write_enable = we; end
        bus_ready = 1; bus_data_fetched = rdata;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(posedge clock); #1;
            ok = master ? m1_done : m0_done;
        end
        m0_read_enable = 0; m0_write_enable = 0; m1_read_enable = 0; m1_write_enable = 0;
        bus_ready = 0;
        @(posedge clock); #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #23;
        checks++;
        if ({m0_done, m0_error, m1_done, m1_error, bus_read_enable, bus_write_enable, bus_owner, bus_busy} !== 8'h00) begin
            errors++; $display("FAIL reset_flags: got %b required 00000000",
                {m0_done, m0_error, m1_done, m1_error, bus_read_enable, bus_write_enable, bus_owner, bus_busy});
        end
        checks++;
        if ({m0_data_fetched, m1_data_fetched, bus_address, bus_write_data} !== 128'd0) begin
            errors++; $display("FAIL reset_data: got %h %h %h %h required all zero",
                m0_data_fetched, m1_data_fetched, bus_address, bus_write_data);
        end
        apply_reset();
    endtask

    task automatic test_read();
        int strobes;
        apply_reset();
        m0_address = 32'h0000_1000; m0_format = 3'b010; m0_read_enable = 1;
        @(posedge clock); #1;
        checks++;
        if ({bus_read_enable, bus_write_enable, bus_busy, bus_owner} !== 4'b1010 || bus_address !== 32'h0000_1000 || bus_format !== 3'b010) begin
            errors++; $display("FAIL read_grant: got re/we/busy/owner=%b addr=%h fmt=%b required 1010 00001000 010",
                {bus_read_enable, bus_write_enable, bus_busy, bus_owner}, bus_address, bus_format);
        end
        strobes = 1;
        @(posedge clock); #1; strobes += int'(bus_read_enable);
        @(posedge clock); #1; strobes += int'(bus_read_enable);
        bus_ready = 1; bus_data_fetched = 32'hCAFE_F00D;
        @(posedge clock); #1;
        checks++;
        if (strobes !== 3 || bus_read_enable !== 1'b0) begin
            errors++; $display("FAIL read_strobe_len: got %0d cycles, re_after=%b required 3, 0", strobes, bus_read_enable);
        end
        checks++;
        if (m0_done !== 1'b1 || m0_data_fetched !== 32'hCAFE_F00D) begin
            errors++; $display("FAIL read_done: got done=%b data=%h required 1 cafef00d", m0_done, m0_data_fetched);
        end
        checks++;
        if ({m1_done, m1_error, m0_error} !== 3'b000 || m1_data_fetched !== 32'd0) begin
            errors++; $display("FAIL read_m1_quiet: got %b %h required 000 00000000", {m1_done, m1_error, m0_error}, m1_data_fetched);
        end
        bus_ready = 0; m0_read_enable = 0; bus_data_fetched = 32'h0;
        @(posedge clock); #1;
        checks++;
        if (m0_done !== 1'b0 || bus_busy !== 1'b0 || m0_data_fetched !== 32'hCAFE_F00D) begin
            errors++; $display("FAIL read_after: got done=%b busy=%b data=%h required 0 0 cafef00d", m0_done, bus_busy, m0_data_fetched);
        end
    endtask

    task automatic test_arbitration();
        logic [3:0] rr_seq, fp_seq;
        int rr_n, fp_n;
        bit rr_prev, fp_prev, fp_m1_seen;
        rr_seq = '0; fp_seq = '1; rr_n = 0; fp_n = 0; rr_prev = 0; fp_prev = 0; fp_m1_seen = 0;
        apply_reset();
        m0_address = 32'h0000_2000; m1_address = 32'h0000_3000;
        m0_read_enable = 1; m1_read_enable = 1; bus_ready = 1; bus_data_fetched = 32'h1111_2222;
        for (int c = 0; c < 40 && (rr_n < 4 || fp_n < 4); c++) begin
            @(posedge clock); #1;
            if (bus_busy && !rr_prev && rr_n < 4) begin rr_seq[rr_n] = bus_owner; rr_n++; end
            if (fp_bus_busy && !fp_prev && fp_n < 4) begin fp_seq[fp_n] = fp_bus_owner; fp_n++; end
            if (fp_m1_done) fp_m1_seen = 1;
            rr_prev = bus_busy; fp_prev = fp_bus_busy;
        end
        m0_read_enable = 0; m1_read_enable = 0; bus_ready = 0;
        checks++;
        if (rr_n !== 4 || rr_seq !== 4'b1010) begin
            errors++; $display("FAIL rr_order: got %0d grants seq(b3..b0)=%b required 4 1010", rr_n, rr_seq);
        end
        checks++;
        if (fp_n !== 4 || fp_seq !== 4'b0000 || fp_m1_seen) begin
            errors++; $display("FAIL fp_order: got %0d grants seq=%b m1_done_seen=%b required 4 0000 0", fp_n, fp_seq, fp_m1_seen);
        end
    endtask

    task automatic test_write();
        bit ok;
        apply_reset();
        run_txn(1'b1, 1'b1, 1'b0, 32'h0000_4000, 32'h0BAD_BEEF, ok);
        checks++;
        if (!ok || m1_data_fetched !== 32'h0BAD_BEEF) begin
            errors++; $display("FAIL m1_prime_read: got ok=%b data=%h required 1 0badbeef", ok, m1_data_fetched);
        end
        m1_address = 32'hFF00_0000; m1_write_data = 32'h1234_5678; m1_format = 3'b010;
        m1_read_enable = 1; m1_write_enable = 1; bus_data_fetched = 32'hDEAD_DEAD;
        @(posedge clock); #1;
        checks++;
        if ({bus_write_enable, bus_read_enable, bus_owner} !== 3'b101 || bus_address !== 32'hFF00_0000 || bus_write_data !== 32'h1234_5678) begin
            errors++; $display("FAIL write_bus: got we/re/owner=%b addr=%h wdata=%h required 101 ff000000 12345678",
                {bus_write_enable, bus_read_enable, bus_owner}, bus_address, bus_write_data);
        end
        bus_ready = 1;
        @(posedge clock); #1;
        checks++;
        if (m1_done !== 1'b1 || m0_done !== 1'b0 || m1_data_fetched !== 32'h0BAD_BEEF) begin
            errors++; $display("FAIL write_done: got m1_done=%b m0_done=%b data=%h required 1 0 0badbeef", m1_done, m0_done, m1_data_fetched);
        end
        m1_read_enable = 0; m1_write_enable = 0; bus_ready = 0;
        @(posedge clock); #1;
    endtask

    task automatic test_timeout();
        bit ok;
        int busy_cycles;
        apply_reset();
        run_txn(1'b0, 1'b1, 1'b0, 32'h0000_5000, 32'h55AA_55AA, ok);
        checks++;
        if (!ok || m0_data_fetched !== 32'h55AA_55AA) begin
            errors++; $display("FAIL m0_prime_read: got ok=%b data=%h required 1 55aa55aa", ok, m0_data_fetched);
        end
        m0_address = 32'h0000_6000; m0_read_enable = 1; bus_ready = 0;
        @(posedge clock); #1;
        busy_cycles = int'(bus_busy);
        for (int c = 0; c < 20 && !m0_done; c++) begin
            @(posedge clock); #1;
            if (bus_busy) busy_cycles++;
        end
        checks++;
        if (busy_cycles !== 4 || m0_done !== 1'b1) begin
            errors++; $display("FAIL timeout_len: got %0d busy cycles done=%b required 4 1", busy_cycles, m0_done);
        end
        checks++;
        if (m0_error !== 1'b1 || m0_data_fetched !== 32'd0 || m1_error !== 1'b0) begin
            errors++; $display("FAIL timeout_err: got err=%b data=%h m1_err=%b required 1 00000000 0", m0_error, m0_data_fetched, m1_error);
        end
        m0_read_enable = 0;
        @(posedge clock); #1;
        checks++;
        if (m0_error !== 1'b1 || m0_done !== 1'b0) begin
            errors++; $display("FAIL timeout_err_hold: got err=%b done=%b required 1 0", m0_error, m0_done);
        end
        m0_read_enable = 1; bus_data_fetched = 32'h7777_0001;
        @(posedge clock); #1;
        checks++;
        if (m0_error !== 1'b0 || bus_busy !== 1'b1) begin
            errors++; $display("FAIL timeout_err_clear: got err=%b busy=%b required 0 1", m0_error, bus_busy);
        end
        bus_ready = 1;
        @(posedge clock); #1;
        checks++;
        if (m0_done !== 1'b1 || m0_error !== 1'b0 || m0_data_fetched !== 32'h7777_0001) begin
            errors++; $display("FAIL timeout_recover: got done=%b err=%b data=%h required 1 0 77770001", m0_done, m0_error, m0_data_fetched);
        end
        m0_read_enable = 0; bus_ready = 0;
        @(posedge clock); #1;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        m0_address = 32'h0000_7000; m0_read_enable = 1;
        m1_address = 32'hFF00_0004; m1_write_data = 32'hA5A5_A5A5; m1_write_enable = 1;
        @(posedge clock); #1;
        checks++;
        if (bus_owner !== 1'b0 || bus_read_enable !== 1'b1) begin
            errors++; $display("FAIL mid_first_grant: got owner=%b re=%b required 0 1", bus_owner, bus_read_enable);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({bus_read_enable, bus_write_enable, bus_busy, m0_done, m1_done} !== 5'b00000) begin
            errors++; $display("FAIL mid_async: got re/we/busy/d0/d1=%b required 00000",
                {bus_read_enable, bus_write_enable, bus_busy, m0_done, m1_done});
        end
        m0_read_enable = 0;
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        checks++;
        if (bus_owner !== 1'b1 || bus_write_enable !== 1'b1 || m0_done !== 1'b0) begin
            errors++; $display("FAIL mid_m1_grant: got owner=%b we=%b m0_done=%b required 1 1 0", bus_owner, bus_write_enable, m0_done);
        end
        bus_ready = 1;
        @(posedge clock); #1;
        checks++;
        if (m1_done !== 1'b1 || m0_done !== 1'b0) begin
            errors++; $display("FAIL mid_m1_done: got m1_done=%b m0_done=%b required 1 0", m1_done, m0_done);
        end
        m1_write_enable = 0; bus_ready = 0; m0_read_enable = 1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        checks++;
        if (bus_owner !== 1'b0 || bus_busy !== 1'b1) begin
            errors++; $display("FAIL mid_m0_after: got owner=%b busy=%b required 0 1", bus_owner, bus_busy);
        end
        m0_read_enable = 0;
    endtask

    initial begin
        test_reset();
        test_read();
        test_arbitration();
        test_write();
        test_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
